// File: rtl/pll_lock_sequencer.sv
// ============================================================================
// Module   : pll_lock_sequencer
// Purpose  : Sequences PLL reset/lock and gates the system reset on stable lock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module pll_lock_sequencer #(
  parameter int RESET_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 12000,
  parameter int STABLE_CYCLES  = 1200,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_resetb,
  output logic       sys_reset_n,
  output logic       ready,
  output logic       fail,
  output logic       lock_lost,
  output logic [3:0] retry_count
);

  localparam int MAX_RT    = (RESET_CYCLES > TIMEOUT_CYCLES) ? RESET_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_PARAM = (MAX_RT > STABLE_CYCLES) ? MAX_RT : STABLE_CYCLES;
  localparam int CNT_W     = $clog2(MAX_PARAM) + 1;

  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAILED    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [1:0]       sync_q, sync_d;
  logic             pll_resetb_q, pll_resetb_d;
  logic             sys_reset_n_q, sys_reset_n_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;
  logic             lock_lost_q, lock_lost_d;
  logic             locked_s;
  logic             attempt_failed;

  assign locked_s = sync_q[1];

  always_comb begin
    sync_d         = {sync_q[0], pll_locked};
    state_d        = state_q;
    cnt_d          = cnt_q + CNT_ONE;
    retry_d        = retry_q;
    lock_lost_d    = 1'b0;
    attempt_failed = 1'b0;

    case (state_q)
      ST_RESET_PLL: if (cnt_q == RESET_LAST) state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (locked_s)                   state_d = ST_STABLE;
        else if (cnt_q == TIMEOUT_LAST) attempt_failed = 1'b1;
      end
      ST_STABLE: begin
        if (!locked_s)                 attempt_failed = 1'b1;
        else if (cnt_q == STABLE_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d     = ST_RESET_PLL;
          retry_d     = 4'd0;
          lock_lost_d = 1'b1;
        end
      end
      ST_FAILED: state_d = ST_FAILED;
      default:   state_d = ST_RESET_PLL;
    endcase

    // A failed attempt either re-arms the PLL or parks it once retries are spent.
    if (attempt_failed) begin
      if (retry_q == RETRY_LIMIT) begin
        state_d = ST_FAILED;
      end else begin
        retry_d = retry_q + 4'd1;
        state_d = ST_RESET_PLL;
      end
    end

    if ((state_q == ST_RUN) || (state_q == ST_FAILED) || (state_d != state_q)) cnt_d = '0;

    if (restart) begin
      state_d     = ST_RESET_PLL;
      retry_d     = 4'd0;
      cnt_d       = '0;
      lock_lost_d = 1'b0;
    end

    pll_resetb_d  = (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE) || (state_d == ST_RUN);
    sys_reset_n_d = (state_d == ST_RUN);
    ready_d       = (state_d == ST_RUN);
    fail_d        = (state_d == ST_FAILED);
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_RESET_PLL;
      cnt_q         <= '0;
      retry_q       <= 4'd0;
      sync_q        <= 2'b00;
      pll_resetb_q  <= 1'b0;
      sys_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
      fail_q        <= 1'b0;
      lock_lost_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      sync_q        <= sync_d;
      pll_resetb_q  <= pll_resetb_d;
      sys_reset_n_q <= sys_reset_n_d;
      ready_q       <= ready_d;
      fail_q        <= fail_d;
      lock_lost_q   <= lock_lost_d;
    end
  end

  assign pll_resetb  = pll_resetb_q;
  assign sys_reset_n = sys_reset_n_q;
  assign ready       = ready_q;
  assign fail        = fail_q;
  assign lock_lost   = lock_lost_q;
  assign retry_count = retry_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
// ============================================================================
// Module   : tb_pll_lock_sequencer
// Purpose  : Directed and randomized lock waveforms checked against a timeline model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pll_lock_sequencer;

  localparam int R  = 4;
  localparam int T  = 32;
  localparam int S  = 8;
  localparam int M  = 2;
  localparam int NE = 4096;

  logic       clock_in = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_resetb, sys_reset_n, ready, fail, lock_lost;
  logic [3:0] retry_count;

  pll_lock_sequencer #(
    .RESET_CYCLES  (R),
    .TIMEOUT_CYCLES(T),
    .STABLE_CYCLES (S),
    .MAX_RETRIES   (M)
  ) dut (
    .clock_in   (clock_in),
    .reset_n    (reset_n),
    .pll_locked (pll_locked),
    .restart    (restart),
    .pll_resetb (pll_resetb),
    .sys_reset_n(sys_reset_n),
    .ready      (ready),
    .fail       (fail),
    .lock_lost  (lock_lost),
    .retry_count(retry_count)
  );

  always #5 clock_in = ~clock_in;

  // lk[e] is the pll_locked level sampled at rising edge e; exp_v[e] the outputs after it.
  bit         lk    [NE];
  logic [8:0] exp_v [NE];
  int         g = 0;
  int         valid_from = 0;
  int         n_asserts = 0;
  int         n_fail = 0;

  function automatic bit ls(int e);
    if (e - 2 < valid_from || e - 2 < 0 || e - 2 >= NE) return 1'b0;
    return lk[e - 2];
  endfunction

  function automatic void set_exp(int e, int n, bit p, bit sy, bit rd, bit fl, bit ll, int rc);
    if (e <= n && e < NE) exp_v[e] = {p, sy, rd, fl, ll, 4'(rc)};
  endfunction

  // Walks the attempt timeline: hold, wait for lock, prove stability, run until loss.
  function automatic void build(int s, int n);
    int e, rc, k, w, st, f, r;
    bit ll, done;
    e = s; rc = 0; ll = 1'b0; done = 1'b0;
    while (!done && e <= n) begin
      for (k = 0; k < R; k++)
        set_exp(e + k, n, 1'b0, 1'b0, 1'b0, 1'b0, (k == 0) ? ll : 1'b0, rc);
      ll = 1'b0;
      w  = e + R;
      set_exp(w, n, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rc);
      st = -1; f = -1; r = -1;
      for (k = 1; k <= T; k++) begin
        if (ls(w + k)) begin st = w + k; break; end
        if (k < T) set_exp(w + k, n, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rc);
      end
      if (st < 0) begin
        f = w + T;
      end else begin
        set_exp(st, n, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rc);
        for (k = 1; k <= S; k++) begin
          if (!ls(st + k)) begin f = st + k; break; end
          if (k == S) r = st + S;
          else        set_exp(st + k, n, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rc);
        end
      end
      if (r >= 0) begin
        set_exp(r, n, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, rc);
        k = 1;
        while (r + k <= n && ls(r + k)) begin
          set_exp(r + k, n, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, rc);
          k++;
        end
        e = r + k; rc = 0; ll = 1'b1;
      end else if (rc == M) begin
        for (k = f; k <= n; k++) set_exp(k, n, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, rc);
        done = 1'b1;
      end else begin
        rc++;
        e = f;
      end
    end
  endfunction

  function automatic logic [8:0] outs();
    return {pll_resetb, sys_reset_n, ready, fail, lock_lost, retry_count};
  endfunction

  task automatic chk(string tag, int e);
    n_asserts++;
    assert (outs() === exp_v[e]) else begin
      n_fail++;
      $error("FAIL %s edge %0d: observed %b required %b (pll,sys,rdy,fail,ll,retry)",
             tag, e, outs(), exp_v[e]);
    end
    n_asserts++;
    assert ((fail & ready) === 1'b0) else begin
      n_fail++;
      $error("FAIL %s_excl edge %0d: observed fail=%b ready=%b required not both 1", tag, e, fail, ready);
    end
    n_asserts++;
    assert ((retry_count <= 4'(M)) === 1'b1) else begin
      n_fail++;
      $error("FAIL %s_bound edge %0d: observed retry=%0d required <= %0d", tag, e, retry_count, M);
    end
  endtask

  task automatic chk_reset(string tag);
    n_asserts++;
    assert (outs() === 9'b0) else begin
      n_fail++;
      $error("FAIL %s: observed %b required %b", tag, outs(), 9'b0);
    end
  endtask

  task automatic run_to(int n, int rs_edge, string tag);
    while (g < n) begin
      pll_locked = lk[g + 1];
      restart    = (g + 1 == rs_edge);
      @(posedge clock_in);
      g++;
      #1;
      chk(tag, g);
    end
    restart = 1'b0;
  endtask

  task automatic do_reset(string tag);
    #3 reset_n = 1'b0;
    #1 chk_reset(tag);
    repeat (2) begin @(posedge clock_in); g++; end
    #1 chk_reset({tag, "_held"});
    @(negedge clock_in);
    reset_n    = 1'b1;
    valid_from = g + 1;
  endtask

  initial begin
    int s;
    int d;
    repeat (3) begin @(posedge clock_in); g++; end
    #1 chk_reset("por");
    @(negedge clock_in);
    reset_n    = 1'b1;
    valid_from = g + 1;

    // Normal start, then a one-cycle lock drop while running.
    s = g;
    for (int e = s + 1; e <= s + 100; e++) lk[e] = (e >= s + 14) && (e != s + 40);
    build(s, s + 100);
    run_to(s + 100, -1, "normal_and_loss");

    // Restart while running with lock high; let WAIT_LOCK run to the edge before timeout.
    s = g + 1;
    for (int e = s; e <= s + 35; e++) lk[e] = 1'b0;
    build(s, s + 35);
    run_to(s + 35, s, "restart_in_run");

    // Restart lands on the timeout edge, then the PLL never locks.
    s = g + 1;
    for (int e = s; e <= s + 115; e++) lk[e] = 1'b0;
    build(s, s + 115);
    run_to(s + 115, s, "never_locks");

    // Glitchy lock from FAILED via restart; final lock drop coincides with the next restart.
    s = g + 1;
    for (int e = s; e <= s + 45; e++)
      lk[e] = ((e - s >= 10) && (e - s <= 14)) || (e - s >= 18);
    lk[s + 44] = 1'b0;
    build(s, s + 45);
    run_to(s + 45, s, "glitchy");

    for (int i = 0; i < 4; i++) begin
      s = g + 1;
      d = int'($urandom_range(0, 45));
      for (int e = s; e <= s + 200; e++)
        lk[e] = (e - s >= d) && ($urandom_range(0, 19) != 0);
      build(s, s + 200);
      run_to(s + 200, s, "random");
    end

    // Asynchronous reset during STABLE, then during RUN.
    s = g + 1;
    for (int e = s; e <= s + 10; e++) lk[e] = (e - s >= 6);
    build(s, s + 10);
    run_to(s + 10, s, "to_stable");
    do_reset("reset_in_stable");

    for (int i = 0; i < 2; i++) begin
      s = g;
      for (int e = s + 1; e <= s + 40; e++) lk[e] = (e >= s + 14);
      build(s, s + 40);
      run_to(s + 40, -1, "after_reset");
      if (i == 0) do_reset("reset_in_run");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
